// File: rtl/fm_axi_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite-style register slave between NUM_REQ req/done requesters.
// One single-beat write or read per grant; returns data/response and counts non-OKAY responses.
module fm_axi_master_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_ID_BIT_COUNT = 6
) (
  input  logic                                clk_axi,
  input  logic                                reset_axi_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]               req_wdata,
  output logic [NUM_REQ-1:0]                  req_done,
  output logic [31:0]                         req_rdata,
  output logic [1:0]                          req_resp,
  output logic [AXI_ADDR_WIDTH-1:0]           m_awaddr,
  output logic [AXI_ID_BIT_COUNT-1:0]         m_awid,
  output logic                                m_awvalid,
  input  logic                                m_awready,
  output logic [31:0]                         m_wdata,
  output logic [3:0]                          m_wstrb,
  output logic                                m_wlast,
  output logic                                m_wvalid,
  input  logic                                m_wready,
  input  logic                                m_bvalid,
  input  logic [1:0]                          m_bresp,
  input  logic [AXI_ID_BIT_COUNT-1:0]         m_bid,
  output logic                                m_bready,
  output logic [AXI_ADDR_WIDTH-1:0]           m_araddr,
  output logic [AXI_ID_BIT_COUNT-1:0]         m_arid,
  output logic                                m_arvalid,
  input  logic                                m_arready,
  input  logic [31:0]                         m_rdata,
  input  logic [1:0]                          m_rresp,
  input  logic                                m_rlast,
  input  logic                                m_rvalid,
  input  logic [AXI_ID_BIT_COUNT-1:0]         m_rid,
  output logic                                m_rready,
  output logic [15:0]                         err_count,
  output logic                                busy,
  output logic [2:0]                          dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshakes: a channel transfers on the rising clk_axi edge where valid and ready are both high;
  // a valid, once raised, is held with stable payload until that edge.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, idx_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q, rdata_q;
  logic [1:0]                resp_q;
  logic                      aw_done_q, w_done_q;
  logic [15:0]               err_q;

  logic                      grant_found;
  logic [IDX_W-1:0]          grant_idx, cand;
  logic [AXI_ADDR_WIDTH-1:0] grant_addr;
  logic [31:0]               grant_wdata;

  logic unused_ids;
  assign unused_ids = ^{m_bid, m_rid};

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_addr  = '0;
    grant_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_addr  = req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        grant_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_axi or negedge reset_axi_n) begin
    if (!reset_axi_n) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_found) state_d = req_write[grant_idx] ? S_WADDR : S_RADDR;
      S_WADDR: if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_d = S_WRESP;
      S_WRESP: if (m_bvalid) state_d = S_DONE;
      S_RADDR: if (m_arready) state_d = S_RDATA;
      S_RDATA: if (m_rvalid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    req_done  = '0;
    case (state_q)
      S_WADDR: begin
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
      end
      S_WRESP: m_bready = 1'b1;
      S_RADDR: m_arvalid = 1'b1;
      S_RDATA: m_rready = 1'b1;
      S_DONE:  req_done[idx_q] = 1'b1;
      default: ;
    endcase
  end

  // Response/data registers are loaded on entry to DONE so they change together with the done pulse.
  always_ff @(posedge clk_axi or negedge reset_axi_n) begin
    if (!reset_axi_n) begin
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            idx_q     <= grant_idx;
            ptr_q     <= grant_idx;
            addr_q    <= grant_addr;
            wdata_q   <= grant_wdata;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        S_WADDR: begin
          if (m_awready) aw_done_q <= 1'b1;
          if (m_wready)  w_done_q  <= 1'b1;
        end
        S_WRESP: if (m_bvalid) resp_q <= m_bresp;
        S_RDATA: begin
          if (m_rvalid) begin
            rdata_q <= m_rdata;
            resp_q  <= m_rlast ? m_rresp : 2'b10;
          end
        end
        S_DONE: begin
          if (resp_q != 2'b00 && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_awid    = {{(AXI_ID_BIT_COUNT-IDX_W){1'b0}}, idx_q};
  assign m_arid    = {{(AXI_ID_BIT_COUNT-IDX_W){1'b0}}, idx_q};
  assign m_wdata   = wdata_q;
  assign m_wstrb   = 4'hF;
  assign m_wlast   = 1'b1;
  assign req_rdata = rdata_q;
  assign req_resp  = resp_q;
  assign err_count = err_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fm_axi_master_arbiter.sv
// Directed bench for fm_axi_master_arbiter: scripted slave, held-request driver, grant-order scoreboard.
module tb_fm_axi_master_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int IDW = 6;

  logic              clk_axi, reset_axi_n;
  logic [NR-1:0]     req_valid, req_write, req_done;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*32-1:0]  req_wdata;
  logic [31:0]       req_rdata;
  logic [1:0]        req_resp;
  logic [AW-1:0]     m_awaddr, m_araddr;
  logic [IDW-1:0]    m_awid, m_arid, m_bid, m_rid;
  logic              m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [31:0]       m_wdata, m_rdata;
  logic [3:0]        m_wstrb;
  logic              m_bvalid, m_bready, m_arvalid, m_arready;
  logic [1:0]        m_bresp, m_rresp;
  logic              m_rlast, m_rvalid, m_rready;
  logic [15:0]       err_count;
  logic              busy;
  logic [2:0]        dbg_state;

  fm_axi_master_arbiter #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_ID_BIT_COUNT(IDW)) dut (
    .clk_axi(clk_axi), .reset_axi_n(reset_axi_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rid(m_rid),
    .m_rready(m_rready), .err_count(err_count), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial begin
    clk_axi = 1'b0;
    forever #5 clk_axi = ~clk_axi;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave configuration (delays counted in cycles after valid/ready is first seen)
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  logic        rlast_cfg = 1'b1;

  initial begin
    m_awready = 1'b0;
    forever begin
      @(negedge clk_axi); m_awready = 1'b0;
      if (m_awvalid) begin
        for (int k = 0; k < aw_dly && m_awvalid; k++) @(negedge clk_axi);
        m_awready = m_awvalid;
      end
    end
  end

  initial begin
    m_wready = 1'b0;
    forever begin
      @(negedge clk_axi); m_wready = 1'b0;
      if (m_wvalid) begin
        for (int k = 0; k < w_dly && m_wvalid; k++) @(negedge clk_axi);
        m_wready = m_wvalid;
      end
    end
  end

  initial begin
    m_bvalid = 1'b0; m_bresp = 2'b00; m_bid = '0;
    forever begin
      @(negedge clk_axi); m_bvalid = 1'b0;
      if (m_bready) begin
        for (int k = 0; k < b_dly && m_bready; k++) @(negedge clk_axi);
        m_bvalid = m_bready; m_bresp = bresp_cfg;
      end
    end
  end

  initial begin
    m_arready = 1'b0;
    forever begin
      @(negedge clk_axi); m_arready = 1'b0;
      if (m_arvalid) begin
        for (int k = 0; k < ar_dly && m_arvalid; k++) @(negedge clk_axi);
        m_arready = m_arvalid;
      end
    end
  end

  initial begin
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0; m_rid = '0;
    forever begin
      @(negedge clk_axi); m_rvalid = 1'b0;
      if (m_rready) begin
        for (int k = 0; k < r_dly && m_rready; k++) @(negedge clk_axi);
        m_rvalid = m_rready; m_rdata = rdata_cfg; m_rresp = rresp_cfg; m_rlast = rlast_cfg;
      end
    end
  end

  // Channel monitor: handshake counts, last accepted fields, valid-hold/stability violations
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, proto_err = 0, split_cnt = 0;
  logic [IDW-1:0] last_awid = '0, last_arid = '0;
  logic [31:0] last_awaddr = '0, last_araddr = '0, last_wdata = '0;
  logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic [31:0] aw_hold = '0, w_hold = '0, ar_hold = '0;
  logic [NR-1:0] prev_done = '0;

  always @(posedge clk_axi) begin
    if (reset_axi_n) begin
      if (aw_pend && (!m_awvalid || m_awaddr != aw_hold)) proto_err++;
      if (w_pend && (!m_wvalid || m_wdata != w_hold)) proto_err++;
      if (ar_pend && (!m_arvalid || m_araddr != ar_hold)) proto_err++;
      if (m_awvalid && m_awready) begin aw_hs++; last_awid = m_awid; last_awaddr = m_awaddr; end
      if (m_wvalid && m_wready) begin w_hs++; last_wdata = m_wdata; end
      if (m_bvalid && m_bready) b_hs++;
      if (m_arvalid && m_arready) begin ar_hs++; last_arid = m_arid; last_araddr = m_araddr; end
      if (m_rvalid && m_rready) r_hs++;
    end
    aw_pend = reset_axi_n && m_awvalid && !m_awready; aw_hold = m_awaddr;
    w_pend  = reset_axi_n && m_wvalid && !m_wready;   w_hold  = m_wdata;
    ar_pend = reset_axi_n && m_arvalid && !m_arready; ar_hold = m_araddr;
  end

  always @(negedge clk_axi) begin
    if (m_awvalid && !m_wvalid) split_cnt++;
    if (req_done != '0 && prev_done != '0) proto_err++;
    if ($countones(req_done) > 1) proto_err++;
    prev_done = req_done;
  end

  // Scoreboard of grant order
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;

  task automatic check_order(input string tag);
    logic [7:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hFF;
      check(tag, 32'(g), 32'(e));
    end
    check({tag, "_extra"}, 32'(got_q.size()), 32'd0);
    got_q.delete();
  endtask

  // Driver: hold req_valid=mask until n done pulses, optionally dropping it once the grant is taken
  task automatic run_held(input logic [NR-1:0] mask, input logic [NR-1:0] wr, input int n, input bit early);
    int seen, cyc;
    seen = 0; cyc = 0;
    req_write = wr; req_valid = mask;
    while (seen < n && cyc < 300) begin
      @(negedge clk_axi); cyc++;
      if (early && busy) req_valid = '0;
      if (req_done != '0) begin
        seen++;
        for (int i = 0; i < NR; i++) if (req_done[i]) got_q.push_back(8'(i));
        last_rdata = req_rdata; last_resp = req_resp;
      end
    end
    req_valid = '0;
    check("done_count", 32'(seen), 32'(n));
    @(negedge clk_axi);
  endtask

  int b_aw, b_w, b_b, b_ar, b_r, b_split, cyc;

  task automatic snap();
    b_aw = aw_hs; b_w = w_hs; b_b = b_hs; b_ar = ar_hs; b_r = r_hs; b_split = split_cnt;
  endtask

  initial begin
    reset_axi_n = 1'b0;
    req_valid = '0; req_write = '0;
    req_addr  = {32'h0000_0030, 32'h0000_0024, 32'h0000_0014, 32'h0000_0010};
    req_wdata = {32'h3333_4444, 32'h1111_2222, 32'h0BAD_BEEF, 32'hCAFE_F00D};
    repeat (3) @(negedge clk_axi);
    reset_axi_n = 1'b1;
    @(negedge clk_axi);

    // Reset state
    check("rst_handshake", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(req_done), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_resp_rdata", {req_rdata[29:0], req_resp}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("fixed_w_fields", 32'({m_wstrb, m_wlast}), 32'h1F);

    // 1: single write, AW/W same cycle, B two cycles later
    b_dly = 2; snap();
    exp_q.push_back(8'd0);
    run_held(4'b0001, 4'b0001, 1, 1'b0);
    check_order("t1_grant");
    check("t1_aw_hs", 32'(aw_hs - b_aw), 32'd1);
    check("t1_w_hs", 32'(w_hs - b_w), 32'd1);
    check("t1_awid", 32'(last_awid), 32'd0);
    check("t1_awaddr", last_awaddr, 32'h10);
    check("t1_wdata", last_wdata, 32'hCAFE_F00D);
    check("t1_resp", 32'(last_resp), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: W accepted three cycles before AW
    b_dly = 0; aw_dly = 3; w_dly = 0; snap();
    exp_q.push_back(8'd1);
    run_held(4'b0010, 4'b0010, 1, 1'b0);
    check_order("t2_grant");
    check("t2_split_cycles", 32'(split_cnt - b_split), 32'd3);
    check("t2_aw_hs", 32'(aw_hs - b_aw), 32'd1);
    check("t2_w_hs", 32'(w_hs - b_w), 32'd1);
    check("t2_b_hs", 32'(b_hs - b_b), 32'd1);
    check("t2_awid", 32'(last_awid), 32'd1);
    aw_dly = 0;

    // 3: read from req2, data after four cycles
    r_dly = 4; rdata_cfg = 32'h1234_5678; snap();
    exp_q.push_back(8'd2);
    run_held(4'b0100, 4'b0000, 1, 1'b0);
    check_order("t3_grant");
    check("t3_rdata", last_rdata, 32'h1234_5678);
    check("t3_arid", 32'(last_arid), 32'd2);
    check("t3_araddr", last_araddr, 32'h24);
    check("t3_ar_r_hs", 32'((ar_hs - b_ar) * 16 + (r_hs - b_r)), 32'h11);
    r_dly = 0;

    // 5: error responses; writes leave req_rdata unchanged
    bresp_cfg = 2'b10;
    run_held(4'b1000, 4'b1000, 1, 1'b0);
    check("t5_bresp", 32'(last_resp), 32'd2);
    check("t5_err1", 32'(err_count), 32'd1);
    check("t5_rdata_kept", last_rdata, 32'h1234_5678);
    bresp_cfg = 2'b00; rresp_cfg = 2'b11; rdata_cfg = 32'hA5A5_0001;
    run_held(4'b0001, 4'b0000, 1, 1'b0);
    check("t5_rresp", 32'(last_resp), 32'd3);
    check("t5_err2", 32'(err_count), 32'd2);
    check("t5_rdata", last_rdata, 32'hA5A5_0001);
    rresp_cfg = 2'b00; rlast_cfg = 1'b0; rdata_cfg = 32'h5A5A_0002;
    run_held(4'b0010, 4'b0000, 1, 1'b0);
    check("t5_rlast_resp", 32'(last_resp), 32'd2);
    check("t5_err3", 32'(err_count), 32'd3);
    check("t5_rlast_rdata", last_rdata, 32'h5A5A_0002);
    rlast_cfg = 1'b1;
    got_q.delete();

    // 6: reset while waiting in RDATA
    r_dly = 20; req_write = '0; req_valid = 4'b0100; cyc = 0;
    while (!m_rready && cyc < 50) begin @(negedge clk_axi); cyc++; end
    check("t6_reach_rdata", 32'(m_rready), 32'd1);
    reset_axi_n = 1'b0;
    #1;
    check("t6_rst_handshake", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 32'd0);
    check("t6_rst_busy_done", 32'({busy, req_done}), 32'd0);
    check("t6_rst_err", 32'(err_count), 32'd0);
    @(negedge clk_axi);
    req_valid = '0; r_dly = 0; reset_axi_n = 1'b1;
    @(negedge clk_axi);
    check("t6_no_done", 32'(got_q.size()), 32'd0);
    exp_q.push_back(8'd0); exp_q.push_back(8'd3);
    run_held(4'b1001, 4'b0000, 2, 1'b0);
    check_order("t6_order");

    // 4: all four held for eight transactions
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i % 4));
    run_held(4'b1111, 4'b0101, 8, 1'b0);
    check_order("t4_rr");
    check("t4_err", 32'(err_count), 32'd0);

    // Requester withdraws after grant: transaction still completes with a done pulse
    snap();
    exp_q.push_back(8'd2);
    run_held(4'b0100, 4'b0100, 1, 1'b1);
    check_order("t7_grant");
    check("t7_b_hs", 32'(b_hs - b_b), 32'd1);
    check("t7_wdata", last_wdata, 32'h1111_2222);

    check("protocol", 32'(proto_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
